// File: rtl/roberts_cross_neg_stream_if.sv
// Pixel-in / edge-out stream bundle for the Roberts Cross negative-diagonal engine.
// master = pixel source + pixel sink side, slave = the engine.
interface roberts_cross_neg_stream_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pixel;
  logic       out_eol;
  logic       frame_done;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_pixel, out_eol, frame_done
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_pixel, out_eol, frame_done
  );
endinterface

// File: rtl/roberts_cross_neg_stream.sv
// Streaming Roberts Cross negative-diagonal edge magnitude, |p(i,j+1) - p(i+1,j)|, zero on borders.
// Latency 1 cycle from accepting p(r,j) to out(r-1,j); in_ready falls combinationally with out_ready when the output register is full.
module roberts_cross_neg_stream #(
  parameter int ROWS = 242,
  parameter int COLS = 247
) (
  input logic                       clk,
  input logic                       rst_n,
  roberts_cross_neg_stream_if.slave s
);

  localparam int CW = (COLS > 2) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {FILL, STREAM, FLUSH, DRAIN} state_t;

  state_t          state_q;
  logic [CW-1:0]   ic_q;
  logic [CW-1:0]   fc_q;
  logic [RW-1:0]   ir_q;
  logic [7:0]      lb [COLS];
  logic            out_valid_q;
  logic [7:0]      out_pixel_q;
  logic            out_eol_q;
  logic            frame_done_q;

  logic            load;
  logic            in_rdy;
  logic            in_acc;
  logic            last_col;
  logic            last_row;
  logic            border;
  logic [CW-1:0]   ic_nxt;
  logic [7:0]      up_pix;
  logic signed [8:0] diff;
  logic signed [8:0] mag;
  logic [7:0]      edge_pix;

  always_comb begin
    load   = !out_valid_q || s.out_ready;
    in_rdy = 1'b0;
    case (state_q)
      FILL:    in_rdy = 1'b1;
      STREAM:  in_rdy = load;
      default: in_rdy = 1'b0;
    endcase
    // Hold in_ready low for the whole time reset is asserted.
    in_rdy   = in_rdy && rst_n;
    in_acc   = s.in_valid && in_rdy;
    last_col = (ic_q == LAST_COL);
    last_row = (ir_q == LAST_ROW);
    ic_nxt   = last_col ? '0 : ic_q + 1'b1;
    // lb[j+1] still holds row r-1 because only lb[j] is overwritten by this pixel.
    up_pix   = last_col ? 8'd0 : lb[ic_nxt];
    diff     = $signed({1'b0, up_pix}) - $signed({1'b0, s.in_pixel});
    mag      = (diff < 0) ? -diff : diff;
    edge_pix = mag[7:0];
    border   = (ir_q == RW'(1)) || (ic_q == '0) || last_col;
  end

  always_ff @(posedge clk) begin
    if (in_acc) begin
      lb[ic_q] <= s.in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      ic_q         <= '0;
      ir_q         <= '0;
      fc_q         <= '0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= 8'd0;
      out_eol_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (s.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        FILL: begin
          if (in_acc) begin
            ic_q <= ic_nxt;
            if (last_col) begin
              ir_q    <= ir_q + 1'b1;
              state_q <= STREAM;
            end
          end
        end

        STREAM: begin
          if (in_acc) begin
            out_valid_q <= 1'b1;
            out_pixel_q <= border ? 8'd0 : edge_pix;
            out_eol_q   <= last_col;
            ic_q        <= ic_nxt;
            if (last_col) begin
              if (last_row) begin
                ir_q    <= '0;
                state_q <= FLUSH;
              end else begin
                ir_q <= ir_q + 1'b1;
              end
            end
          end
        end

        FLUSH: begin
          // The last output row is entirely border, so it is synthesised without input.
          if (load) begin
            out_valid_q <= 1'b1;
            out_pixel_q <= 8'd0;
            out_eol_q   <= (fc_q == LAST_COL);
            if (fc_q == LAST_COL) begin
              fc_q    <= '0;
              state_q <= DRAIN;
            end else begin
              fc_q <= fc_q + 1'b1;
            end
          end
        end

        default: begin
          if (out_valid_q && s.out_ready) begin
            frame_done_q <= 1'b1;
            ic_q         <= '0;
            ir_q         <= '0;
            fc_q         <= '0;
            state_q      <= FILL;
          end
        end
      endcase
    end
  end

  assign s.in_ready   = in_rdy;
  assign s.out_valid  = out_valid_q;
  assign s.out_pixel  = out_pixel_q;
  assign s.out_eol    = out_eol_q;
  assign s.frame_done = frame_done_q;

endmodule

// File: tb/tb_roberts_cross_neg_stream.sv
// Bench for roberts_cross_neg_stream on a 4x5 frame: vector table of frame patterns plus
// hand sequences for stall, mid-frame reset and back-to-back frames, scored against a frame-level model.
module tb_roberts_cross_neg_stream;
  localparam int R = 4;
  localparam int C = 5;
  localparam int N = R * C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  roberts_cross_neg_stream_if bus ();

  roberts_cross_neg_stream #(.ROWS(R), .COLS(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus)
  );

  typedef struct {
    logic [7:0] pix;
    logic       eol;
  } exp_t;

  typedef struct {
    int kind;      // 0 ramp, 1 checkerboard, 2 column stripes, 3 random
    int vpct;      // in_valid probability in percent
    int rpct;      // out_ready probability in percent
    int stall_idx; // pixel index at which out_ready is held low for 10 cycles, -1 none
    int exp_sum;   // hand-derived sum of all output pixels, -1 when not known
  } vec_t;

  exp_t       exp_q[$];
  logic [7:0] frm[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int fd_cyc = -1;
  int out_sum = 0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_pix;
  logic       prev_eol;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void gen_frame(input int kind);
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        case (kind)
          0:       frm.push_back(8'(10 * i + j));
          1:       frm.push_back(((i + j) % 2 == 1) ? 8'd255 : 8'd0);
          2:       frm.push_back((j % 2 == 1) ? 8'd255 : 8'd0);
          default: frm.push_back(8'($urandom_range(0, 255)));
        endcase
      end
    end
  endfunction

  // Reference: out(i,j) = |p(i,j+1) - p(i+1,j)| inside, 0 on every border pixel.
  function automatic void model_frame(input int base);
    exp_t e;
    int   d;
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        if (i == 0 || i == R - 1 || j == 0 || j == C - 1) begin
          d = 0;
        end else begin
          d = int'(frm[base + i * C + j + 1]) - int'(frm[base + (i + 1) * C + j]);
          if (d < 0) d = -d;
        end
        e.pix = 8'(d);
        e.eol = (j == C - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic step(input bit iv, input logic [7:0] px, input bit ordy, output bit acc);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_pixel  = px;
    bus.out_ready = ordy;
    #1;
    if (bus.frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (prev_hold) begin
      check("hold_stable", int'({bus.out_valid, bus.out_eol, bus.out_pixel}),
            int'({1'b1, prev_eol, prev_pix}));
    end
    if (bus.out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        check("extra_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_pixel", int'(bus.out_pixel), int'(e.pix));
        check("out_eol", int'(bus.out_eol), int'(e.eol));
        out_sum += int'(bus.out_pixel);
      end
    end
    prev_hold = bus.out_valid && !ordy;
    prev_pix  = bus.out_pixel;
    prev_eol  = bus.out_eol;
    acc = iv && bus.in_ready;
    cyc++;
  endtask

  task automatic run_frames(input int nfr, input int vpct, input int rpct,
                            input int stall_idx, output int first_acc);
    int idx = 0;
    int n = 0;
    int stall_left = 10;
    int budget = 40 * N * nfr + 200;
    bit acc;
    bit iv;
    bit ordy;
    first_acc = -1;
    while ((idx < nfr * N || exp_q.size() > 0) && n < budget) begin
      if (idx == stall_idx && stall_left > 0) begin
        step(1'b1, frm[idx], 1'b0, acc);
        check("stall_in_ready", int'(bus.in_ready), 0);
        check("stall_pending", int'(bus.out_valid), 1);
        check("stall_no_accept", int'(acc), 0);
        stall_left--;
      end else begin
        iv   = (idx < nfr * N) && ($urandom_range(0, 99) < vpct);
        ordy = ($urandom_range(0, 99) < rpct);
        step(iv, (idx < nfr * N) ? frm[idx] : 8'd0, ordy, acc);
      end
      if (acc) begin
        if (first_acc < 0) first_acc = cyc - 1;
        idx++;
      end
      n++;
    end
    if (n >= budget) check("frame_timeout", 1, 0);
    step(1'b0, 8'd0, 1'b1, acc);
  endtask

  vec_t vecs[8];

  initial begin
    int  fd0;
    int  first;
    bit  acc;

    vecs[0] = '{0, 100, 100, -1, 54};
    vecs[1] = '{1, 100, 100, -1, 0};
    vecs[2] = '{2, 100, 100, -1, 1530};
    vecs[3] = '{0, 100, 100, 12, 54};
    vecs[4] = '{3, 60, 50, -1, -1};
    vecs[5] = '{3, 80, 50, -1, -1};
    vecs[6] = '{3, 100, 100, -1, -1};
    vecs[7] = '{2, 50, 50, -1, 1530};

    bus.in_valid  = 1'b0;
    bus.in_pixel  = 8'd0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_pixel", int'(bus.out_pixel), 0);
    check("rst_out_eol", int'(bus.out_eol), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    rst_n = 1'b1;
    #1;
    check("fill_in_ready", int'(bus.in_ready), 1);

    for (int v = 0; v < 8; v++) begin
      frm.delete();
      gen_frame(vecs[v].kind);
      model_frame(0);
      fd0 = fd_cnt;
      out_sum = 0;
      run_frames(1, vecs[v].vpct, vecs[v].rpct, vecs[v].stall_idx, first);
      check("frame_done_count", fd_cnt - fd0, 1);
      if (vecs[v].exp_sum >= 0) check("out_sum", out_sum, vecs[v].exp_sum);
      if (vecs[v].vpct == 100 && vecs[v].rpct == 100 && vecs[v].stall_idx < 0)
        check("frame_latency", fd_cyc - first, N + C + 1);
    end

    // Reset in the middle of row 2, then a clean frame.
    frm.delete();
    gen_frame(0);
    model_frame(0);
    for (int k = 0; k < 2 * C + 2; k++) step(1'b1, frm[k], 1'b1, acc);
    fd0 = fd_cnt;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 0);
    check("mid_rst_out_pixel", int'(bus.out_pixel), 0);
    check("mid_rst_out_eol", int'(bus.out_eol), 0);
    exp_q.delete();
    prev_hold = 1'b0;
    repeat (3) step(1'b0, 8'd0, 1'b1, acc);
    rst_n = 1'b1;
    repeat (2) step(1'b0, 8'd0, 1'b1, acc);
    check("mid_rst_no_frame_done", fd_cnt - fd0, 0);
    frm.delete();
    gen_frame(3);
    model_frame(0);
    fd0 = fd_cnt;
    run_frames(1, 100, 100, -1, first);
    check("post_rst_frame_done", fd_cnt - fd0, 1);
    check("post_rst_latency", fd_cyc - first, N + C + 1);

    // Two frames streamed back to back at full throughput.
    frm.delete();
    gen_frame(3);
    gen_frame(0);
    model_frame(0);
    model_frame(N);
    fd0 = fd_cnt;
    out_sum = 0;
    run_frames(2, 100, 100, -1, first);
    check("b2b_frame_done_count", fd_cnt - fd0, 2);
    check("b2b_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
